// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared sizing constants and grant encoding for the register-file write-port arbiter.
package regfile_wb_arbiter_pkg;
  localparam int XLEN_DEF         = 32;
  localparam int NREG_DEF         = 32;
  localparam int REG_AW           = 5;
  localparam int BUF_DEPTH_DEF    = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WB   = 2'd1,
    GNT_BUF  = 2'd2
  } grantT;
endpackage

// File: rtl/regfile_wb_buf.sv
// Small circular FIFO holding LLU results; the head is visible combinationally
// so the arbiter can write it in the same cycle it is granted.
module regfile_wb_buf #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] pushData,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wrPtr;
  logic [PW:0]  rdPtr;
  logic         doPush;
  logic         doPop;

  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_ONE;
      if (doPop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[PW-1:0]] <= pushData;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[PW-1:0] == rdPtr[PW-1:0]) && (wrPtr[PW] != rdPtr[PW]);
  assign head  = mem[rdPtr[PW-1:0]];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between WB and buffered LLU results,
// tracking pending LLU destinations in a busy scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int NREG         = NREG_DEF,
  parameter int BUF_DEPTH    = BUF_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              llu_valid,
  input  logic [REG_AW-1:0] llu_rd,
  input  logic [XLEN-1:0]   llu_data,
  output logic              llu_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              stall_req,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              err_waw
);
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
  localparam logic [SCW-1:0] STARVE_ONE = SCW'(1);

  logic [XLEN+REG_AW-1:0] head;
  logic [REG_AW-1:0]      headRd;
  logic [XLEN-1:0]        headData;
  logic                   bufFull;
  logic                   bufEmpty;
  logic                   headPresent;
  logic                   push;
  logic                   pop;
  logic                   wbReal;
  logic                   issSet;
  logic                   popClr;
  logic                   errNow;
  logic [SCW-1:0]         starveCnt;
  logic [NREG-1:0]        busy;
  logic [NREG-1:0]        busyNext;
  logic                   errWaw;
  grantT                  grant;

  regfile_wb_buf #(.W(XLEN + REG_AW), .DEPTH(BUF_DEPTH)) uBuf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData ({llu_rd, llu_data}),
    .pop      (pop),
    .full     (bufFull),
    .empty    (bufEmpty),
    .head     (head)
  );

  assign headRd      = head[XLEN+REG_AW-1:XLEN];
  assign headData    = head[XLEN-1:0];
  assign headPresent = !bufEmpty;
  assign llu_ready   = !bufFull;
  assign push        = llu_valid && !bufFull;
  assign wbReal      = wb_valid && (wb_rd != '0);
  assign stall_req   = headPresent && (starveCnt >= STARVE_MAX);

  always_comb begin
    grant = GNT_NONE;
    if (stall_req)        grant = GNT_BUF;
    else if (wbReal)      grant = GNT_WB;
    else if (headPresent) grant = GNT_BUF;
  end

  assign pop = (grant == GNT_BUF);

  // rd=0 entries still pop, they just never reach the register file.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (grant == GNT_WB) begin
        rf_we    = 1'b1;
        rf_waddr = wb_rd;
        rf_wdata = wb_data;
      end else if (grant == GNT_BUF && headRd != '0) begin
        rf_we    = 1'b1;
        rf_waddr = headRd;
        rf_wdata = headData;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       starveCnt <= '0;
    else if (!headPresent || pop)  starveCnt <= '0;
    else if (starveCnt != STARVE_MAX) starveCnt <= starveCnt + STARVE_ONE;
  end

  assign issSet = iss_valid && (iss_rd != '0);
  assign popClr = pop && (headRd != '0);

  // Set wins over a same-cycle clear; bit 0 is hard-wired idle.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : gBusy
      if (gi == 0) begin : gZero
        assign busyNext[gi] = 1'b0;
      end else begin : gReg
        assign busyNext[gi] = (issSet && iss_rd == REG_AW'(gi)) ||
                              (busy[gi] && !(popClr && headRd == REG_AW'(gi)));
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busyNext;
  end

  assign rs1_busy = busy[rs1_addr];
  assign rs2_busy = busy[rs2_addr];

  assign errNow = (issSet && busy[iss_rd] && !(popClr && headRd == iss_rd)) ||
                  ((grant == GNT_WB) && busy[wb_rd]) ||
                  (push && (llu_rd != '0) && !busy[llu_rd]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         errWaw <= 1'b0;
    else if (errNow) errWaw <= 1'b1;
  end

  assign err_waw = errWaw;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue/array model is checked every
// negedge, plus literal expectations at each scenario step.
module tb_regfile_wb_arbiter;
  localparam int LIM   = 4;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        llu_valid = 1'b0;
  logic [4:0]  llu_rd = '0;
  logic [31:0] llu_data = '0;
  logic        llu_ready;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        err_waw;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .err_waw(err_waw)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: buffered results as a queue, busy as a bit array.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entT;

  entT mq[$];
  bit  mBusy[32];
  int  mStarve = 0;
  bit  mErr = 1'b0;

  always @(negedge clk) begin
    bit headP, st, wbR, gBuf, gWb, eWe;
    logic [4:0]  eAddr;
    logic [31:0] eData;
    if (started) begin
      headP = (mq.size() > 0);
      st    = headP && (mStarve >= LIM);
      wbR   = wb_valid && (wb_rd != 0);
      gBuf  = st || (!wbR && headP);
      gWb   = !st && wbR;
      eWe = 1'b0; eAddr = '0; eData = '0;
      if (gWb) begin
        eWe = 1'b1; eAddr = wb_rd; eData = wb_data;
      end else if (gBuf && mq[0].rd != 0) begin
        eWe = 1'b1; eAddr = mq[0].rd; eData = mq[0].data;
      end
      if (rst) begin
        eWe = 1'b0; eAddr = '0; eData = '0;
      end
      chk("m_rf_we", rf_we, eWe);
      chk("m_rf_waddr", rf_waddr, eAddr);
      chk("m_rf_wdata", rf_wdata, eData);
      chk("m_stall_req", stall_req, st);
      chk("m_llu_ready", llu_ready, mq.size() < DEPTH);
      chk("m_rs1_busy", rs1_busy, mBusy[rs1_addr]);
      chk("m_rs2_busy", rs2_busy, mBusy[rs2_addr]);
      chk("m_err_waw", err_waw, mErr);
      if (rf_we) $display("write t=%0t addr=%0d data=%08h stall=%0b", $time, rf_waddr, rf_wdata, stall_req);
    end
  end

  always @(posedge clk or posedge rst) begin
    bit headP, st, wbR, gBuf, gWb, pushOk;
    logic [4:0] clrRd;
    if (rst) begin
      mq.delete();
      foreach (mBusy[i]) mBusy[i] = 1'b0;
      mStarve = 0;
      mErr = 1'b0;
    end else begin
      headP  = (mq.size() > 0);
      st     = headP && (mStarve >= LIM);
      wbR    = wb_valid && (wb_rd != 0);
      gBuf   = st || (!wbR && headP);
      gWb    = !st && wbR;
      pushOk = llu_valid && (mq.size() < DEPTH);
      clrRd  = gBuf ? mq[0].rd : 5'd0;
      if (iss_valid && iss_rd != 0 && mBusy[iss_rd] && clrRd != iss_rd) mErr = 1'b1;
      if (gWb && mBusy[wb_rd]) mErr = 1'b1;
      if (pushOk && llu_rd != 0 && !mBusy[llu_rd]) mErr = 1'b1;
      if (gBuf) void'(mq.pop_front());
      if (clrRd != 0) mBusy[clrRd] = 1'b0;
      if (iss_valid && iss_rd != 0) mBusy[iss_rd] = 1'b1;
      if (pushOk) mq.push_back('{rd: llu_rd, data: llu_data});
      if (!headP || gBuf) mStarve = 0;
      else if (mStarve < LIM) mStarve = mStarve + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    started = 1'b1;
    step(); step();
    rst = 1'b0;
    rs1_addr = 5'd7; rs2_addr = 5'd3;
    look();
    chk("idle_we", rf_we, 0); chk("idle_ready", llu_ready, 1);
    chk("idle_stall", stall_req, 0); chk("idle_err", err_waw, 0);
    chk("idle_busy", rs1_busy, 0);
    step();

    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    look();
    chk("wb_we", rf_we, 1); chk("wb_addr", rf_waddr, 5); chk("wb_data", rf_wdata, 32'hDEADBEEF);
    step();
    wb_rd = 5'd0;
    look();
    chk("wb_rd0_we", rf_we, 0); chk("wb_rd0_addr", rf_waddr, 0);
    step();
    wb_valid = 1'b0;

    iss_valid = 1'b1; iss_rd = 5'd7;
    look(); chk("iss7_before", rs1_busy, 0);
    step();
    iss_valid = 1'b0;
    look(); chk("iss7_busy", rs1_busy, 1);
    step();
    llu_valid = 1'b1; llu_rd = 5'd7; llu_data = 32'h12;
    look(); chk("llu7_ready", llu_ready, 1); chk("llu7_nowrite", rf_we, 0);
    step();
    llu_valid = 1'b0;
    look();
    chk("llu7_we", rf_we, 1); chk("llu7_addr", rf_waddr, 7); chk("llu7_data", rf_wdata, 32'h12);
    chk("llu7_still_busy", rs1_busy, 1);
    step();
    look(); chk("llu7_cleared", rs1_busy, 0); chk("llu7_done", rf_we, 0);
    step();

    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'hA0;
    llu_valid = 1'b1; llu_rd = 5'd9; llu_data = 32'h99;
    step();
    llu_valid = 1'b0;
    for (int i = 0; i < LIM; i++) begin
      look(); chk("starve_wb_wins", stall_req, 0); chk("starve_wb_addr", rf_waddr, 10);
      step();
    end
    look();
    chk("starve_stall", stall_req, 1); chk("starve_head_addr", rf_waddr, 9);
    chk("starve_head_data", rf_wdata, 32'h99);
    step();
    look(); chk("starve_resume", stall_req, 0); chk("starve_resume_addr", rf_waddr, 10);
    step();

    for (int r = 11; r <= 13; r++) begin
      iss_valid = 1'b1; iss_rd = 5'(r);
      step();
    end
    iss_valid = 1'b0;
    llu_valid = 1'b1; llu_rd = 5'd11; llu_data = 32'hB1;
    look(); chk("full_ready0", llu_ready, 1);
    step();
    llu_rd = 5'd12; llu_data = 32'hB2;
    look(); chk("full_ready1", llu_ready, 1);
    step();
    llu_rd = 5'd13; llu_data = 32'hB3;
    look(); chk("full_ready2", llu_ready, 0);
    step();
    n = 0;
    while (!llu_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL full_ready_timeout actual=0 required=1");
    end
    step();
    llu_valid = 1'b0;
    wb_valid = 1'b0;
    rs1_addr = 5'd13; rs2_addr = 5'd11;
    repeat (10) step();
    look();
    chk("drain_busy13", rs1_busy, 0); chk("drain_busy11", rs2_busy, 0);
    chk("drain_err", err_waw, 0); chk("drain_ready", llu_ready, 1);
    step();

    llu_valid = 1'b1; llu_rd = 5'd0; llu_data = 32'h55;
    step();
    llu_valid = 1'b0;
    look(); chk("rd0_nowrite", rf_we, 0); chk("rd0_ready", llu_ready, 1);
    step();

    rs2_addr = 5'd3;
    iss_valid = 1'b1; iss_rd = 5'd3;
    step(); step();
    iss_valid = 1'b0;
    look(); chk("waw_set", err_waw, 1); chk("waw_busy3", rs2_busy, 1);
    repeat (3) step();
    look(); chk("waw_sticky", err_waw, 1);
    step();

    iss_valid = 1'b1; iss_rd = 5'd20; rs1_addr = 5'd20;
    step();
    iss_valid = 1'b0;
    look(); chk("pre_rst_busy20", rs1_busy, 1);
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_err", err_waw, 0); chk("async_rst_busy", rs1_busy, 0);
    step();
    rst = 1'b0;
    look(); chk("post_rst_err", err_waw, 0); chk("post_rst_ready", llu_ready, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
